multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//   Moore FSM sequencing the multicycle MIPS datapath (shared ALU + unified instruction/data memory).
//   Executes R-type, lw, sw, beq, addi and j over 3-5 cycles each.
//   Stalls on a memory ready handshake. Traps on unsupported opcodes.
//   Drives all datapath mux selects and write enables. Sits beside the ALU decoder, which consumes alu_op.
// PARAMETERS
//   STATE_W   4   width of the state register and of the state_dbg output
// PORTS
//   clk        in   1  single clock; all state changes on rising edge
//   rst_n      in   1  synchronous, active-low reset
//   opcode     in   6  instr[31:26] from the instruction register
//   zero       in   1  ALU zero flag (beq compare)
//   mem_ready  in   1  memory has completed the current read/write this cycle
//   mem_req    out  1  memory access active
//   mem_write  out  1  memory write
//   i_or_d     out  1  memory address select: 0=PC, 1=ALUOut
//   ir_write   out  1  instruction register load
//   pc_en      out  1  PC load = pc_write | (branch & zero)
//   pc_src     out  2  00=ALU result, 01=ALUOut, 10=jump target
//   alu_src_a  out  1  0=PC, 1=reg A
//   alu_src_b  out  2  00=reg B, 01=const 4, 10=SignImm, 11=SignImm<<2
//   alu_op     out  2  00=add, 01=sub, 10=use funct
//   reg_dst    out  1  0=rt, 1=rd
//   mem_to_reg out  1  0=ALUOut, 1=memory data
//   reg_write  out  1  register file write
//   illegal_op out  1  sticky trap flag
//   state_dbg  out  STATE_W  current state encoding
// BEHAVIOUR
//   State encodings:
//     FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7,
//     BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12.
//   Reset: a clock edge with rst_n=0 forces state=FETCH; this includes mid-instruction reset, which abandons the instruction.
//   While rst_n=0, mem_req, mem_write, ir_write, pc_en and reg_write are forced to 0.
//   After reset the outputs are the FETCH values below and illegal_op=0.
//   Outputs not listed for a state are 0.
//   FETCH:
//     mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//     ir_write=pc_en=mem_ready (gated).
//     Next state: mem_ready ? DECODE : FETCH.
//   DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precomputed into ALUOut). Next state by opcode:
//     23h,2Bh -> MEMADR; 00h -> EXEC; 04h -> BRANCH; 08h -> ADDIEX; 02h -> JUMP; any other -> TRAP.
//   MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
//   MEMRD: mem_req=1, i_or_d=1. Next: mem_ready ? MEMWB : MEMRD.
//   MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
//   MEMWR: mem_req=1, mem_write=1, i_or_d=1; held stable until mem_ready. Next: mem_ready ? FETCH : MEMWR.
//   EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
//   ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
//   BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next: FETCH.
//   ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
//   ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
//   JUMP: pc_src=10, pc_en=1. Next: FETCH.
//   TRAP: illegal_op=1, all enables 0; remains in TRAP until reset.
//   Cycle counts with mem_ready tied to 1: lw=5, sw=4, R/addi=4, beq=3, j=3.
//   Each extra cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
//   opcode is sampled only in DECODE (and MEMADR for the lw/sw split); the IR is stable after FETCH.
//   State values 13-15 are unreachable; if entered, next state is FETCH with all enables 0.
// TESTING
//   Reset: rst_n=0 for 2 cycles while mem_ready=1 -> pc_en=ir_write=0, state_dbg=0; rst_n=1 -> FETCH outputs.
//   Trace, mem_ready=1, opcode=23h (lw) -> states 0,1,2,3,4,0; reg_write=1 only in MEMWB with mem_to_reg=1.
//   beq opcode=04h: zero=1 -> pc_en=1, pc_src=01 in BRANCH; zero=0 -> pc_en=0; both then return to FETCH.
//   sw with mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, state=5, then FETCH.
//   opcode=3Fh -> TRAP, illegal_op=1, no enables for 10 cycles; rst_n=0 -> FETCH, illegal_op=0.
//   Reset asserted in MEMRD -> next state FETCH, no reg_write pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath with one shared ALU and one
// unified instruction/data memory. It drives every mux select and write enable.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_EXEC   = STATE_W'(6),
    S_ALUWB  = STATE_W'(7),
    S_BRANCH = STATE_W'(8),
    S_ADDIEX = STATE_W'(9),
    S_ADDIWB = STATE_W'(10),
    S_JUMP   = STATE_W'(11),
    S_TRAP   = STATE_W'(12)
  } state_t;

  state_t state;
  state_t next_state;
  logic   illegal_q;

  // Ungated control values; the write-type enables are masked by reset below.
  logic       mem_req_c;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       pc_en_c;
  logic       reg_write_c;

  // Memory handshake: mem_req (and mem_write, i_or_d) stay asserted and stable
  // in a memory state until the cycle in which mem_ready=1; that cycle
  // completes the transfer and the FSM leaves the state on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state  = S_FETCH;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    i_or_d      = 1'b0;
    ir_write_c  = 1'b0;
    pc_en_c     = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_c = 1'b0;

    unique case (state)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_c = mem_ready;
        pc_en_c    = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c  = 1'b1;
        i_or_d     = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        i_or_d      = 1'b1;
        next_state  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en_c    = zero;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en_c    = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        // Unused encodings recover to FETCH with everything idle.
        next_state = S_FETCH;
      end
    endcase
  end

  assign mem_req    = mem_req_c   & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign ir_write   = ir_write_c  & rst_n;
  assign pc_en      = pc_en_c     & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign illegal_op = illegal_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state traces per instruction class,
// memory stalls, branch resolution, trap and reset behaviour.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a,
  //  alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write}
  logic [14:0] ctrl;
  assign ctrl = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write};

  localparam logic [14:0] C_FETCH  = 15'b1_0_0_1_1_00_0_01_00_0_0_0;
  localparam logic [14:0] C_FSTALL = 15'b1_0_0_0_0_00_0_01_00_0_0_0;
  localparam logic [14:0] C_DECODE = 15'b0_0_0_0_0_00_0_11_00_0_0_0;
  localparam logic [14:0] C_MEMADR = 15'b0_0_0_0_0_00_1_10_00_0_0_0;
  localparam logic [14:0] C_MEMRD  = 15'b1_0_1_0_0_00_0_00_00_0_0_0;
  localparam logic [14:0] C_MEMWB  = 15'b0_0_0_0_0_00_0_00_00_0_1_1;
  localparam logic [14:0] C_MEMWR  = 15'b1_1_1_0_0_00_0_00_00_0_0_0;
  localparam logic [14:0] C_EXEC   = 15'b0_0_0_0_0_00_1_00_10_0_0_0;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_00_0_00_00_1_0_1;
  localparam logic [14:0] C_BR0    = 15'b0_0_0_0_0_01_1_00_01_0_0_0;
  localparam logic [14:0] C_BR1    = 15'b0_0_0_0_1_01_1_00_01_0_0_0;
  localparam logic [14:0] C_ADDIWB = 15'b0_0_0_0_0_00_0_00_00_0_0_1;
  localparam logic [14:0] C_JUMP   = 15'b0_0_0_0_1_10_0_00_00_0_0_0;
  localparam logic [14:0] C_IDLE   = 15'b0_0_0_0_0_00_0_00_00_0_0_0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Advance one active edge and settle at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
    step();
    step();
    total++;
    if (state_dbg !== 4'd0) begin
      bad++; $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    total++;
    if ({pc_en, ir_write, mem_req, mem_write, reg_write} !== 5'b00000) begin
      bad++; $display("FAIL reset_enables: got %b want 00000",
                      {pc_en, ir_write, mem_req, mem_write, reg_write});
    end
    total++;
    if (illegal_op !== 1'b0) begin
      bad++; $display("FAIL reset_illegal: got %b want 0", illegal_op);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (ctrl !== C_FETCH) begin
      bad++; $display("FAIL reset_fetch_ctrl: got %b want %b", ctrl, C_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [3:0]  st[5];
    logic [14:0] cw[5];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    cw = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB};
    opcode = 6'h23; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (state_dbg !== st[i] || ctrl !== cw[i]) begin
        bad++; $display("FAIL lw_trace[%0d]: got state=%0d ctrl=%b want state=%0d ctrl=%b",
                        i, state_dbg, ctrl, st[i], cw[i]);
      end
      step();
    end
    total++;
    if (state_dbg !== 4'd0) begin
      bad++; $display("FAIL lw_return: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  st_r[4];
    logic [14:0] cw_r[4];
    logic [3:0]  st_i[4];
    logic [14:0] cw_i[4];
    logic [3:0]  st_j[3];
    logic [14:0] cw_j[3];
    st_r = '{4'd0, 4'd1, 4'd6, 4'd7};
    cw_r = '{C_FETCH, C_DECODE, C_EXEC, C_ALUWB};
    st_i = '{4'd0, 4'd1, 4'd9, 4'd10};
    cw_i = '{C_FETCH, C_DECODE, C_MEMADR, C_ADDIWB};
    st_j = '{4'd0, 4'd1, 4'd11};
    cw_j = '{C_FETCH, C_DECODE, C_JUMP};
    mem_ready = 1'b1;
    opcode = 6'h00;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (state_dbg !== st_r[i] || ctrl !== cw_r[i]) begin
        bad++; $display("FAIL rtype_trace[%0d]: got state=%0d ctrl=%b want state=%0d ctrl=%b",
                        i, state_dbg, ctrl, st_r[i], cw_r[i]);
      end
      step();
    end
    opcode = 6'h08;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (state_dbg !== st_i[i] || ctrl !== cw_i[i]) begin
        bad++; $display("FAIL addi_trace[%0d]: got state=%0d ctrl=%b want state=%0d ctrl=%b",
                        i, state_dbg, ctrl, st_i[i], cw_i[i]);
      end
      step();
    end
    opcode = 6'h02;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (state_dbg !== st_j[i] || ctrl !== cw_j[i]) begin
        bad++; $display("FAIL j_trace[%0d]: got state=%0d ctrl=%b want state=%0d ctrl=%b",
                        i, state_dbg, ctrl, st_j[i], cw_j[i]);
      end
      step();
    end
    total++;
    if (state_dbg !== 4'd0) begin
      bad++; $display("FAIL alu_ops_return: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_beq();
    opcode = 6'h04; mem_ready = 1'b1;
    for (int z = 0; z < 2; z++) begin
      zero = z[0];
      step();
      total++;
      if (state_dbg !== 4'd1) begin
        bad++; $display("FAIL beq_decode z=%0d: got %0d want 1", z, state_dbg);
      end
      step();
      total++;
      if (state_dbg !== 4'd8 || ctrl !== (z == 1 ? C_BR1 : C_BR0)) begin
        bad++; $display("FAIL beq_branch z=%0d: got state=%0d ctrl=%b want state=8 ctrl=%b",
                        z, state_dbg, ctrl, (z == 1 ? C_BR1 : C_BR0));
      end
      step();
      total++;
      if (state_dbg !== 4'd0) begin
        bad++; $display("FAIL beq_return z=%0d: got %0d want 0", z, state_dbg);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_stall();
    opcode = 6'h2B; mem_ready = 1'b1;
    step();
    step();
    total++;
    if (state_dbg !== 4'd2) begin
      bad++; $display("FAIL sw_memadr: got %0d want 2", state_dbg);
    end
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (state_dbg !== 4'd5 || ctrl !== C_MEMWR) begin
        bad++; $display("FAIL sw_hold[%0d]: got state=%0d ctrl=%b want state=5 ctrl=%b",
                        i, state_dbg, ctrl, C_MEMWR);
      end
      mem_ready = (i == 3);
      step();
    end
    total++;
    if (state_dbg !== 4'd0) begin
      bad++; $display("FAIL sw_return: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_fetch_stall();
    opcode = 6'h02; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (state_dbg !== 4'd0 || ctrl !== C_FSTALL) begin
        bad++; $display("FAIL fetch_stall[%0d]: got state=%0d ctrl=%b want state=0 ctrl=%b",
                        i, state_dbg, ctrl, C_FSTALL);
      end
      step();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (ctrl !== C_FETCH) begin
      bad++; $display("FAIL fetch_release: got %b want %b", ctrl, C_FETCH);
    end
    step();
    step();
    step();
    total++;
    if (state_dbg !== 4'd0) begin
      bad++; $display("FAIL fetch_stall_j_return: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_mid_reset();
    opcode = 6'h23; mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    step();
    total++;
    if (state_dbg !== 4'd3) begin
      bad++; $display("FAIL midrst_memrd: got %0d want 3", state_dbg);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++; $display("FAIL midrst_gated_req: got %b want 0", mem_req);
    end
    step();
    total++;
    if (state_dbg !== 4'd0 || reg_write !== 1'b0) begin
      bad++; $display("FAIL midrst_fetch: got state=%0d reg_write=%b want state=0 reg_write=0",
                      state_dbg, reg_write);
    end
    rst_n = 1'b1; mem_ready = 1'b1;
    step();
    total++;
    if (state_dbg !== 4'd1 || reg_write !== 1'b0) begin
      bad++; $display("FAIL midrst_restart: got state=%0d reg_write=%b want state=1 reg_write=0",
                      state_dbg, reg_write);
    end
    repeat (4) step();
    total++;
    if (state_dbg !== 4'd0) begin
      bad++; $display("FAIL midrst_lw_return: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_trap();
    opcode = 6'h3F; mem_ready = 1'b1;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (state_dbg !== 4'd12 || illegal_op !== 1'b1 || ctrl !== C_IDLE) begin
        bad++; $display("FAIL trap_hold[%0d]: got state=%0d illegal=%b ctrl=%b want state=12 illegal=1 ctrl=%b",
                        i, state_dbg, illegal_op, ctrl, C_IDLE);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    total++;
    if (state_dbg !== 4'd0 || illegal_op !== 1'b0) begin
      bad++; $display("FAIL trap_reset: got state=%0d illegal=%b want state=0 illegal=0",
                      state_dbg, illegal_op);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (ctrl !== C_FETCH) begin
      bad++; $display("FAIL trap_reset_fetch: got %b want %b", ctrl, C_FETCH);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_lw();
    test_alu_ops();
    test_beq();
    test_sw_stall();
    test_fetch_stall();
    test_mid_reset();
    test_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
